// File: rtl/red_cord_veto_sequencer.sv
// Ring-0 red cord veto sequencer: sticky trip on torque-with-human or command timeout,
// human-clear hold, explicit re-arm. Define RED_CORD_TRIP_LOG_EN to add the trip_torque log output.
module red_cord_veto_sequencer #(
    parameter int MAX_SAFE_TORQUE    = 300,
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int CLEAR_HOLD_CYCLES  = 1000,
    parameter int CMD_TIMEOUT_CYCLES = 5000,
    parameter int CNT_W              = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      torque_cmd,
    input  logic             torque_cmd_valid,
    input  logic             human_presence_raw,
    input  logic             rearm_req,
    output logic             motor_enable,
    output logic             veto_active,
    output logic [1:0]       ctrl_state,
    output logic [1:0]       trip_cause,
    output logic [CNT_W-1:0] trip_count,
`ifdef RED_CORD_TRIP_LOG_EN
    output logic [31:0]      trip_torque,
`endif
    output logic             rearm_ack
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(CLEAR_HOLD_CYCLES + 1);
    localparam int TO_W   = $clog2(CMD_TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        TRIPPED  = 2'b00,
        CLEARING = 2'b01,
        READY    = 2'b10,
        RUN      = 2'b11
    } state_t;

    state_t            state, state_n;
    logic              sync1, sync2, db_hold;
    logic [DB_W-1:0]   db_cnt;
    logic              presence_db;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              rearm_q, rearm_rise;
    logic              hit_torque, hit_timeout, trip, go_run;

    // Presence asserts as soon as the synchronized sample is high; release waits out the debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            db_hold <= 1'b1;
            db_cnt  <= '0;
        end else begin
            sync1 <= human_presence_raw;
            sync2 <= sync1;
            if (sync2) begin
                db_hold <= 1'b1;
                db_cnt  <= '0;
            end else if (db_hold) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_hold <= 1'b0;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end
    end

    assign presence_db = sync2 | db_hold;
    assign rearm_rise  = rearm_req & ~rearm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TRIPPED;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        go_run       = 1'b0;
        hit_torque   = torque_cmd_valid & presence_db & (torque_cmd > 32'(MAX_SAFE_TORQUE));
        hit_timeout  = (to_cnt == TO_W'(CMD_TIMEOUT_CYCLES));
        trip         = (state == RUN) & (hit_torque | hit_timeout);
        motor_enable = (state == RUN) & ~hit_torque & ~hit_timeout;
        veto_active  = (state != RUN);
        ctrl_state   = state;
        case (state)
            TRIPPED:  if (!presence_db) state_n = CLEARING;
            CLEARING: begin
                if (presence_db)                                  state_n = TRIPPED;
                else if (hold_cnt == HOLD_W'(CLEAR_HOLD_CYCLES - 1)) state_n = READY;
            end
            READY: begin
                if (presence_db) begin
                    state_n = TRIPPED;
                end else if (rearm_rise) begin
                    state_n = RUN;
                    go_run  = 1'b1;
                end
            end
            RUN:      if (trip) state_n = TRIPPED;
            default:  state_n = TRIPPED;
        endcase
    end

    // Hold and timeout counters idle at zero outside their state, so entry always starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt   <= '0;
            to_cnt     <= '0;
            rearm_q    <= 1'b1;
            rearm_ack  <= 1'b0;
            trip_cause <= 2'b00;
            trip_count <= '0;
        end else begin
            rearm_q   <= rearm_req;
            rearm_ack <= go_run;
            if (state != CLEARING) hold_cnt <= '0;
            else                   hold_cnt <= hold_cnt + HOLD_W'(1);
            if (state != RUN || torque_cmd_valid)           to_cnt <= '0;
            else if (to_cnt != TO_W'(CMD_TIMEOUT_CYCLES))   to_cnt <= to_cnt + TO_W'(1);
            if (go_run) begin
                trip_cause <= 2'b00;
            end else if (trip) begin
                trip_cause <= hit_torque ? 2'b01 : 2'b10;
                if (trip_count != {CNT_W{1'b1}}) trip_count <= trip_count + CNT_W'(1);
            end
        end
    end

`ifdef RED_CORD_TRIP_LOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       trip_torque <= '0;
        else if (trip) trip_torque <= hit_torque ? torque_cmd : 32'd0;
    end
`endif

endmodule

// File: tb/tb_red_cord_veto_sequencer.sv
// Directed bench for red_cord_veto_sequencer: timestamp-based model checked every cycle,
// plus literal checkpoints from the test plan.
module tb_red_cord_veto_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] torque_cmd = '0;
    logic        torque_cmd_valid = 1'b0;
    logic        human_presence_raw = 1'b0;
    logic        rearm_req = 1'b0;
    logic        motor_enable, veto_active, rearm_ack;
    logic [1:0]  ctrl_state, trip_cause;
    logic [15:0] trip_count;
`ifdef RED_CORD_TRIP_LOG_EN
    logic [31:0] trip_torque;
`endif

    int n_vec = 0;
    int n_err = 0;

    red_cord_veto_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .torque_cmd         (torque_cmd),
        .torque_cmd_valid   (torque_cmd_valid),
        .human_presence_raw (human_presence_raw),
        .rearm_req          (rearm_req),
        .motor_enable       (motor_enable),
        .veto_active        (veto_active),
        .ctrl_state         (ctrl_state),
        .trip_cause         (trip_cause),
        .trip_count         (trip_count),
`ifdef RED_CORD_TRIP_LOG_EN
        .trip_torque        (trip_torque),
`endif
        .rearm_ack          (rearm_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim, input string name);
        int k = 0;
        while (ctrl_state !== s && k < lim) begin
            tick();
            k++;
        end
        check(name, 32'(ctrl_state), 32'(s));
    endtask

    // Model: presence from a low-streak count, hold/timeout from cycle timestamps.
    int          cyc = 0;
    int          m_state, m_low, m_clr_t0, m_mark, m_cause, m_count;
    logic        m_s1, m_s2, m_rq, m_ack;
    logic [31:0] m_log;
    logic        u_pres, u_trq, u_to, u_rise;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_low = 0; m_clr_t0 = 0; m_mark = 0; m_cause = 0; m_count = 0;
            m_s1 = 1'b1; m_s2 = 1'b1; m_rq = 1'b1; m_ack = 1'b0; m_log = '0;
        end else begin
            u_pres = m_s2 || (m_low < 16);
            u_trq  = torque_cmd_valid && u_pres && (torque_cmd > 32'd300);
            u_to   = (cyc - m_mark) >= 5000;
            u_rise = rearm_req && !m_rq;
            m_ack  = 1'b0;
            case (m_state)
                0: if (!u_pres) begin m_state = 1; m_clr_t0 = cyc + 1; end
                1: if (u_pres) m_state = 0; else if (cyc - m_clr_t0 == 999) m_state = 2;
                2: if (u_pres) m_state = 0;
                   else if (u_rise) begin m_state = 3; m_ack = 1'b1; m_cause = 0; m_mark = cyc + 1; end
                default: begin
                    if (u_trq || u_to) begin
                        m_state = 0;
                        m_cause = u_trq ? 1 : 2;
                        if (m_count < 65535) m_count++;
                        m_log = u_trq ? torque_cmd : 32'd0;
                    end else if (torque_cmd_valid) begin
                        m_mark = cyc + 1;
                    end
                end
            endcase
            if (m_s2) m_low = 0;
            else if (m_low < 1000000) m_low++;
            m_s2 = m_s1;
            m_s1 = human_presence_raw;
            m_rq = rearm_req;
            cyc++;
        end
    end

    logic c_pres, c_trq, c_to, c_en;
    always @(negedge clk) begin
        if (!rst) begin
            c_pres = m_s2 || (m_low < 16);
            c_trq  = torque_cmd_valid && c_pres && (torque_cmd > 32'd300);
            c_to   = (cyc - m_mark) >= 5000;
            c_en   = (m_state == 3) && !c_trq && !c_to;
            check("m_motor_enable", 32'(motor_enable), 32'(c_en));
            check("m_ctrl_state",   32'(ctrl_state),   32'(m_state));
            check("m_veto_active",  32'(veto_active),  32'(m_state != 3));
            check("m_trip_cause",   32'(trip_cause),   32'(m_cause));
            check("m_trip_count",   32'(trip_count),   32'(m_count));
            check("m_rearm_ack",    32'(rearm_ack),    32'(m_ack));
`ifdef RED_CORD_TRIP_LOG_EN
            check("m_trip_torque",  trip_torque,       m_log);
`endif
        end
    end

    initial begin
        repeat (3) tick();
        check("rst_enable", 32'(motor_enable), 0);
        check("rst_veto",   32'(veto_active),  1);
        check("rst_state",  32'(ctrl_state),   0);
        check("rst_cause",  32'(trip_cause),   0);
        check("rst_count",  32'(trip_count),   0);
        check("rst_ack",    32'(rearm_ack),    0);
        rst = 1'b0;

        // 1: debounce + hold, then re-arm
        repeat (18) tick();
        check("t1_tripped_18", 32'(ctrl_state), 0);
        tick();
        check("t1_clearing", 32'(ctrl_state), 1);
        repeat (999) tick();
        check("t1_clear_999", 32'(ctrl_state), 1);
        tick();
        check("t1_ready", 32'(ctrl_state), 2);
        rearm_req = 1'b1;
        tick();
        check("t1_run", 32'(ctrl_state), 3);
        check("t1_enable", 32'(motor_enable), 1);
        check("t1_ack", 32'(rearm_ack), 1);

        // 3: big torque without human is fine; exactly the ceiling with human is fine
        torque_cmd = 32'd5000; torque_cmd_valid = 1'b1;
        #1 check("t3_nohuman_en", 32'(motor_enable), 1);
        tick();
        check("t1_ack_drop", 32'(rearm_ack), 0);
        check("t3_nohuman_run", 32'(ctrl_state), 3);
        human_presence_raw = 1'b1; torque_cmd = 32'd0;
        repeat (3) tick();
        torque_cmd = 32'd300;
        #1 check("t3_equal_en", 32'(motor_enable), 1);
        tick();
        check("t3_equal_run", 32'(ctrl_state), 3);

        // 2: torque trip with human present
        torque_cmd = 32'd301;
        #1 check("t2_same_cycle_en", 32'(motor_enable), 0);
        tick();
        check("t2_state", 32'(ctrl_state), 0);
        check("t2_cause", 32'(trip_cause), 1);
        check("t2_count", 32'(trip_count), 1);
`ifdef RED_CORD_TRIP_LOG_EN
        check("t2_log", trip_torque, 32'd301);
`endif

        // 4: heartbeat timeout
        human_presence_raw = 1'b0; rearm_req = 1'b0; torque_cmd_valid = 1'b0; torque_cmd = 32'd0;
        wait_state(2'b10, 1200, "t4_wait_ready");
        rearm_req = 1'b1;
        tick();
        check("t4_run", 32'(ctrl_state), 3);
        repeat (4999) tick();
        torque_cmd_valid = 1'b1;
        #1 check("t4_pulse_4999_en", 32'(motor_enable), 1);
        tick();
        torque_cmd_valid = 1'b0;
        repeat (4999) tick();
        check("t4_to_4999_en", 32'(motor_enable), 1);
        tick();
        check("t4_to_5000_en", 32'(motor_enable), 0);
        tick();
        check("t4_state", 32'(ctrl_state), 0);
        check("t4_cause", 32'(trip_cause), 2);
        check("t4_count", 32'(trip_count), 2);
`ifdef RED_CORD_TRIP_LOG_EN
        check("t4_log", trip_torque, 32'd0);
`endif

        // 5: presence glitch mid-hold restarts the full sequence; held rearm is not an edge
        rearm_req = 1'b0;
        wait_state(2'b01, 100, "t5_wait_clearing");
        repeat (500) tick();
        human_presence_raw = 1'b1; rearm_req = 1'b1;
        tick();
        human_presence_raw = 1'b0;
        repeat (2) tick();
        check("t5_retrip", 32'(ctrl_state), 0);
        repeat (1016) tick();
        check("t5_still_clearing", 32'(ctrl_state), 1);
        tick();
        check("t5_ready", 32'(ctrl_state), 2);
        repeat (5) tick();
        check("t5_held_rearm", 32'(ctrl_state), 2);
        rearm_req = 1'b0;
        tick();
        check("t5_rearm_low", 32'(ctrl_state), 2);
        rearm_req = 1'b1;
        tick();
        check("t5_run", 32'(ctrl_state), 3);
        check("t5_ack", 32'(rearm_ack), 1);

        // 6: third trip, re-arm, then async reset mid-cycle
        torque_cmd_valid = 1'b1; human_presence_raw = 1'b1;
        repeat (3) tick();
        torque_cmd = 32'd400;
        tick();
        check("t6_count3", 32'(trip_count), 3);
        torque_cmd = 32'd0; human_presence_raw = 1'b0; rearm_req = 1'b0;
        wait_state(2'b10, 1200, "t6_wait_ready");
        rearm_req = 1'b1;
        tick();
        check("t6_run", 32'(ctrl_state), 3);
        check("t6_run_count", 32'(trip_count), 3);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_en", 32'(motor_enable), 0);
        check("t6_rst_count", 32'(trip_count), 0);
        check("t6_rst_state", 32'(ctrl_state), 0);
        check("t6_rst_veto", 32'(veto_active), 1);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("t6_post_state", 32'(ctrl_state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
